// File: rtl/ssp_pkg.sv
// Shared definitions for the shadow-stack-pointer switch controller.
// Optional nesting-depth tracking is enabled with the SSP_NEST_CNT_EN macro.
package ssp_pkg;

    localparam int SSP_W  = 32;
    localparam int NEST_W = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        E_SAVE = 3'd1,
        E_LOAD = 3'd2,
        R_SAVE = 3'd3,
        R_LOAD = 3'd4
    } ssp_state_t;

endpackage

// File: rtl/ssp_nest_cnt.sv
// Saturating exception nesting-depth counter, used only when SSP_NEST_CNT_EN is defined.
// Counts up on every acknowledged exception entry and down on every acknowledged return.
module ssp_nest_cnt
    import ssp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    output logic [NEST_W-1:0] depth,
    output logic              nest_ovf
);

    localparam logic [NEST_W-1:0] DEPTH_MAX = '1;

    // Both ends saturate so a runaway caller can never wrap the depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            depth <= '0;
        end else if (inc && !dec && depth != DEPTH_MAX) begin
            depth <= depth + NEST_W'(1);
        end else if (dec && !inc && depth != '0) begin
            depth <= depth - NEST_W'(1);
        end
    end

    assign nest_ovf = (depth == DEPTH_MAX);

endmodule

// File: rtl/ssp_switch_ctrl.sv
// Swaps the GPR $sp with the shadow stack pointer on exception entry and return.
// Define SSP_NEST_CNT_EN to add nesting-depth tracking and the nest_ovf output.
module ssp_switch_ctrl
    import ssp_pkg::*;
#(
    parameter int WIDTH = SSP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic             mtc0_we,
    input  logic [WIDTH-1:0] mtc0_data,
    input  logic             mfc0_re,
    output logic [WIDTH-1:0] mfc0_data,
    input  logic [WIDTH-1:0] sp_rdata,
    output logic             sp_we,
    output logic [WIDTH-1:0] sp_wdata,
    output logic             ssp_we_s,
    output logic             ssp_re_p,
    output logic [WIDTH-1:0] ssp_wdata,
    input  logic [WIDTH-1:0] ssp_rdata,
    output logic             ack,
    output logic             busy,
    output logic             kmode
`ifdef SSP_NEST_CNT_EN
    ,
    output logic             nest_ovf
`endif
);

    ssp_state_t       state;
    ssp_state_t       next_state;
    logic [WIDTH-1:0] usp;
    logic             eret_switch;

`ifdef SSP_NEST_CNT_EN
    logic [NEST_W-1:0] depth;
    logic              exc_ack;
    logic              eret_ack;

    // Every ack belongs to exactly one of the two request kinds.
    assign exc_ack  = ack && ((state == E_LOAD) || (state == IDLE && exc_req));
    assign eret_ack = ack && !exc_ack;

    ssp_nest_cnt u_nest_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (exc_ack),
        .dec      (eret_ack),
        .depth    (depth),
        .nest_ovf (nest_ovf)
    );

    assign eret_switch = kmode && (depth <= NEST_W'(1));
`else
    assign eret_switch = kmode;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            kmode <= 1'b1;
            usp   <= '0;
        end else begin
            state <= next_state;
            if (state == E_SAVE) begin
                usp <= sp_rdata;
            end
            if (state == E_LOAD) begin
                kmode <= 1'b1;
            end else if (state == R_LOAD) begin
                kmode <= 1'b0;
            end
        end
    end

    // Requests are served strictly by priority; anything lower in the same cycle is dropped.
    always_comb begin
        next_state = state;
        ack        = 1'b0;
        busy       = (state != IDLE);
        sp_we      = 1'b0;
        sp_wdata   = '0;
        ssp_we_s   = 1'b0;
        ssp_re_p   = 1'b0;
        ssp_wdata  = '0;
        mfc0_data  = '0;
        case (state)
            IDLE: begin
                if (exc_req) begin
                    if (!kmode) begin
                        next_state = E_SAVE;
                    end else begin
                        ack = 1'b1;
                    end
                end else if (eret_req) begin
                    if (eret_switch) begin
                        next_state = R_SAVE;
                    end else begin
                        ack = 1'b1;
                    end
                end else if (mtc0_we) begin
                    ssp_we_s  = 1'b1;
                    ssp_wdata = mtc0_data;
                end else if (mfc0_re) begin
                    ssp_re_p  = 1'b1;
                    mfc0_data = ssp_rdata;
                end
            end
            E_SAVE: begin
                next_state = E_LOAD;
            end
            E_LOAD: begin
                ssp_re_p   = 1'b1;
                sp_we      = 1'b1;
                sp_wdata   = ssp_rdata;
                ack        = 1'b1;
                next_state = IDLE;
            end
            R_SAVE: begin
                ssp_we_s   = 1'b1;
                ssp_wdata  = sp_rdata;
                next_state = R_LOAD;
            end
            R_LOAD: begin
                sp_we      = 1'b1;
                sp_wdata   = usp;
                ack        = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule
